// File: rtl/symm_pkg.sv
// Shared types and constants for the symmetric orthogonalization sequencer.
package symm_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned ITER_W_DEF      = 4;

  // Stage indices into the per-stage enable/done vectors
  localparam int unsigned NUM_STG  = 6;
  localparam int unsigned STG_MUL1 = 0;
  localparam int unsigned STG_NORM = 1;
  localparam int unsigned STG_SQRT = 2;
  localparam int unsigned STG_MUL2 = 3;
  localparam int unsigned STG_MUL3 = 4;
  localparam int unsigned STG_SUB  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL1,
    ST_NORM,
    ST_SQRT,
    ST_MUL23,
    ST_SUB,
    ST_DONE,
    ST_ERR
  } symm_state_e;

  // States in which a datapath stage is running
  function automatic logic is_busy(input symm_state_e s);
    return (s == ST_MUL1) || (s == ST_NORM) || (s == ST_SQRT) ||
           (s == ST_MUL23) || (s == ST_SUB);
  endfunction

endpackage

// File: rtl/symm_stage_timer.sv
// Per-state watchdog: counts cycles spent waiting for a stage done.
module symm_stage_timer
  import symm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count is 0 in the first cycle of a state; expired in its TIMEOUT_CYC-th cycle
  assign expired_c = (cnt_q >= LAST);

  // Clear on state change, otherwise saturating increment while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/symm_seq.sv
// Sequencer for the iterative symmetric orthogonalization datapath:
// MUL1 -> NORM -> SQRT -> MUL2||MUL3 -> SUB, repeated iter_num times.
module symm_seq
  import symm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned ITER_W      = ITER_W_DEF
) (
  input  logic              clk_symm,
  input  logic              rst_n_symm,
  input  logic              go_symm,
  input  logic              abort_symm,
  input  logic [ITER_W-1:0] iter_num,
  input  logic              done_mul1,
  input  logic              done_norm,
  input  logic              done_sqrt,
  input  logic              done_mul2,
  input  logic              done_mul3,
  input  logic              done_sub,
  output logic              en_mul1,
  output logic              en_norm,
  output logic              en_sqrt,
  output logic              en_mul2,
  output logic              en_mul3,
  output logic              en_sub,
  output logic              sel_fb,
  output logic              symm_busy,
  output logic              symm_done,
  output logic              symm_err,
  output logic [ITER_W-1:0] iter_cnt
);

  symm_state_e        state_q, state_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               sel_q, sel_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               f2_q, f2_d;
  logic               f3_q, f3_d;
  logic [NUM_STG-1:0] en_q, en_d;

  logic [NUM_STG-1:0] done_v_c;
  logic [NUM_STG-1:0] hit_c;
  logic               m2_c, m3_c;
  logic               expired_c;
  logic [ITER_W:0]    nxt_iter_c;
  logic [ITER_W:0]    n_eff_c;

  assign done_v_c = {done_sub, done_mul3, done_mul2, done_sqrt, done_norm, done_mul1};
  // A done only counts while its stage is enabled
  assign hit_c    = done_v_c & en_q;

  assign nxt_iter_c = {1'b0, iter_q} + (ITER_W + 1)'(1);
  assign n_eff_c    = (iter_num == '0) ? (ITER_W + 1)'(1) : {1'b0, iter_num};

  assign en_mul1   = en_q[STG_MUL1];
  assign en_norm   = en_q[STG_NORM];
  assign en_sqrt   = en_q[STG_SQRT];
  assign en_mul2   = en_q[STG_MUL2];
  assign en_mul3   = en_q[STG_MUL3];
  assign en_sub    = en_q[STG_SUB];
  assign sel_fb    = sel_q;
  assign symm_busy = busy_q;
  assign symm_done = done_q;
  assign symm_err  = err_q;
  assign iter_cnt  = iter_q;

  symm_stage_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk_symm),
    .rst_n    (rst_n_symm),
    .clr      (state_d != state_q),
    .inc      (is_busy(state_q)),
    .expired_c(expired_c)
  );

  // State and registered outputs
  always_ff @(posedge clk_symm or negedge rst_n_symm) begin
    if (!rst_n_symm) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      f2_q    <= 1'b0;
      f3_q    <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      f2_q    <= f2_d;
      f3_q    <= f3_d;
      en_q    <= en_d;
    end
  end

  // Next state, then outputs decoded from the next state so they align with it
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    sel_d   = sel_q;
    err_d   = err_q;
    f2_d    = 1'b0;
    f3_d    = 1'b0;
    en_d    = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    m2_c    = f2_q | hit_c[STG_MUL2];
    m3_c    = f3_q | hit_c[STG_MUL3];

    case (state_q)
      ST_IDLE: begin
        if (go_symm) begin
          state_d = ST_MUL1;
          iter_d  = '0;
          sel_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_MUL1: begin
        if (hit_c[STG_MUL1])  state_d = ST_NORM;
        else if (expired_c)   state_d = ST_ERR;
      end
      ST_NORM: begin
        if (hit_c[STG_NORM])  state_d = ST_SQRT;
        else if (expired_c)   state_d = ST_ERR;
      end
      ST_SQRT: begin
        if (hit_c[STG_SQRT])  state_d = ST_MUL23;
        else if (expired_c)   state_d = ST_ERR;
      end
      ST_MUL23: begin
        f2_d = m2_c;
        f3_d = m3_c;
        if (m2_c && m3_c)     state_d = ST_SUB;
        else if (expired_c)   state_d = ST_ERR;
      end
      ST_SUB: begin
        if (hit_c[STG_SUB]) begin
          if (nxt_iter_c < n_eff_c) begin
            iter_d  = nxt_iter_c[ITER_W-1:0];
            sel_d   = 1'b1;
            state_d = ST_MUL1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (expired_c) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (abort_symm) begin
          state_d = ST_IDLE;
        end else if (go_symm) begin
          state_d = ST_MUL1;
          iter_d  = '0;
          sel_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats done and timeout in every active state
    if (abort_symm && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      iter_d  = iter_q;
    end

    if (state_d == ST_ERR) err_d = 1'b1;

    // MUL23 completion flags live only for one stay in MUL23
    if ((state_d != ST_MUL23) || (state_q != ST_MUL23)) begin
      f2_d = 1'b0;
      f3_d = 1'b0;
    end

    if (!is_busy(state_d)) sel_d = 1'b0;

    case (state_d)
      ST_MUL1:  en_d[STG_MUL1] = 1'b1;
      ST_NORM:  en_d[STG_NORM] = 1'b1;
      ST_SQRT:  en_d[STG_SQRT] = 1'b1;
      ST_MUL23: begin
        en_d[STG_MUL2] = !f2_d;
        en_d[STG_MUL3] = !f3_d;
      end
      ST_SUB:   en_d[STG_SUB]  = 1'b1;
      default:  en_d = '0;
    endcase

    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_symm_seq.sv
// Scoreboard bench for symm_seq: stimulus queues expected output vectors and
// completion cycles; a monitor compares them as the DUT presents outputs.
module tb_symm_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic       abort;
  logic [3:0] iter_num;
  logic       done_mul1, done_norm, done_sqrt, done_mul2, done_mul3, done_sub;
  logic       en_mul1, en_norm, en_sqrt, en_mul2, en_mul3, en_sub;
  logic       sel_fb, symm_busy, symm_done, symm_err;
  logic [3:0] iter_cnt;

  always #5 clk = ~clk;

  symm_seq #(
    .TIMEOUT_CYC(8),
    .ITER_W     (4)
  ) dut (
    .clk_symm  (clk),
    .rst_n_symm(rst_n),
    .go_symm   (go),
    .abort_symm(abort),
    .iter_num  (iter_num),
    .done_mul1 (done_mul1),
    .done_norm (done_norm),
    .done_sqrt (done_sqrt),
    .done_mul2 (done_mul2),
    .done_mul3 (done_mul3),
    .done_sub  (done_sub),
    .en_mul1   (en_mul1),
    .en_norm   (en_norm),
    .en_sqrt   (en_sqrt),
    .en_mul2   (en_mul2),
    .en_mul3   (en_mul3),
    .en_sub    (en_sub),
    .sel_fb    (sel_fb),
    .symm_busy (symm_busy),
    .symm_done (symm_done),
    .symm_err  (symm_err),
    .iter_cnt  (iter_cnt)
  );

  // Enable patterns in the order mul1,norm,sqrt,mul2,mul3,sub
  localparam logic [5:0] E_0  = 6'b000000;
  localparam logic [5:0] E_M1 = 6'b100000;
  localparam logic [5:0] E_NM = 6'b010000;
  localparam logic [5:0] E_SQ = 6'b001000;
  localparam logic [5:0] E_23 = 6'b000110;
  localparam logic [5:0] E_M3 = 6'b000010;
  localparam logic [5:0] E_SB = 6'b000001;

  typedef struct {
    int         cyc;
    logic [13:0] v;
  } exp_t;

  exp_t trace_q[$];
  int   done_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [13:0] outv;
  assign outv = {en_mul1, en_norm, en_sqrt, en_mul2, en_mul3, en_sub,
                 sel_fb, symm_busy, symm_done, symm_err, iter_cnt};

  function automatic logic [13:0] mk(input logic [5:0] en, input logic sel,
                                     input logic busy, input logic dn,
                                     input logic err, input logic [3:0] it);
    return {en, sel, busy, dn, err, it};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [13:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    trace_q.push_back(e);
  endtask

  // Advance to following falling edges; go/abort are one-cycle pulses
  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      go    = 1'b0;
      abort = 1'b0;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stage model: pulses done_X dly[X] cycles after en_X rises (-1 = never)
  int         dly[6];
  int         k[6];
  logic [5:0] prev = '0;
  logic [5:0] done_v = '0;
  int         stray_cyc = -1;
  logic [5:0] en_v;
  assign en_v = {en_sub, en_mul3, en_mul2, en_sqrt, en_norm, en_mul1};
  assign {done_sub, done_mul3, done_mul2, done_sqrt, done_norm, done_mul1} = done_v;

  always @(negedge clk) begin
    for (int s = 0; s < 6; s++) begin
      if (en_v[s]) k[s] = prev[s] ? k[s] + 1 : 0;
      prev[s]   = en_v[s];
      done_v[s] = en_v[s] && (dly[s] >= 0) && (k[s] == dly[s]);
    end
    if (cyc == stray_cyc) done_v[1] = 1'b1;
  end

  // Monitor: checks queued output vectors and completion pulses
  always @(negedge clk) begin
    exp_t e;
    int   d;
    while (trace_q.size() > 0 && trace_q[0].cyc <= cyc) begin
      e = trace_q.pop_front();
      if (e.cyc != cyc) chk("trace_slot", cyc, e.cyc);
      chk("trace", {18'b0, outv}, {18'b0, e.v});
    end
    if (symm_done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", done_q.size(), 1);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d);
      end
    end else if (done_q.size() > 0 && done_q[0] < cyc) begin
      d = done_q.pop_front();
      chk("done_missing", cyc, d);
    end
  end

  int g, h;

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; iter_num = 4'd1;
    for (int s = 0; s < 6; s++) begin dly[s] = 0; k[s] = 0; end
    repeat (2) @(negedge clk);
    chk("reset_outs", {18'b0, outv}, 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("idle_outs", {18'b0, outv}, 32'd0);

    // Single iteration, single-cycle stages
    g = cyc; go = 1'b1; iter_num = 4'd1;
    push(g+1, mk(E_M1, 0, 1, 0, 0, 0));
    push(g+2, mk(E_NM, 0, 1, 0, 0, 0));
    push(g+3, mk(E_SQ, 0, 1, 0, 0, 0));
    push(g+4, mk(E_23, 0, 1, 0, 0, 0));
    push(g+5, mk(E_SB, 0, 1, 0, 0, 0));
    push(g+6, mk(E_0,  0, 0, 1, 0, 0));
    push(g+7, mk(E_0,  0, 0, 0, 0, 0));
    done_q.push_back(g+6);
    step(9);

    // Three iterations with feedback select
    g = cyc; go = 1'b1; iter_num = 4'd3;
    for (int p = 0; p < 3; p++) begin
      push(g+5*p+1, mk(E_M1, p > 0, 1, 0, 0, 4'(p)));
      push(g+5*p+2, mk(E_NM, p > 0, 1, 0, 0, 4'(p)));
      push(g+5*p+3, mk(E_SQ, p > 0, 1, 0, 0, 4'(p)));
      push(g+5*p+4, mk(E_23, p > 0, 1, 0, 0, 4'(p)));
      push(g+5*p+5, mk(E_SB, p > 0, 1, 0, 0, 4'(p)));
    end
    push(g+16, mk(E_0, 0, 0, 1, 0, 2));
    push(g+17, mk(E_0, 0, 0, 0, 0, 2));
    done_q.push_back(g+16);
    step(19);

    // iter_num=0, stray done_norm in MUL1, go ignored while busy
    dly[0] = 2;
    g = cyc; go = 1'b1; iter_num = 4'd0; stray_cyc = g+1;
    push(g+1, mk(E_M1, 0, 1, 0, 0, 0));
    push(g+2, mk(E_M1, 0, 1, 0, 0, 0));
    push(g+3, mk(E_M1, 0, 1, 0, 0, 0));
    push(g+4, mk(E_NM, 0, 1, 0, 0, 0));
    push(g+5, mk(E_SQ, 0, 1, 0, 0, 0));
    push(g+6, mk(E_23, 0, 1, 0, 0, 0));
    push(g+7, mk(E_SB, 0, 1, 0, 0, 0));
    push(g+8, mk(E_0,  0, 0, 1, 0, 0));
    push(g+9, mk(E_0,  0, 0, 0, 0, 0));
    done_q.push_back(g+8);
    step(3);
    go = 1'b1;
    step(8);
    dly[0] = 0; stray_cyc = -1;

    // MUL23 with staggered dones
    dly[3] = 1; dly[4] = 6;
    g = cyc; go = 1'b1; iter_num = 4'd1;
    push(g+4, mk(E_23, 0, 1, 0, 0, 0));
    push(g+5, mk(E_23, 0, 1, 0, 0, 0));
    for (int c = 6; c <= 10; c++) push(g+c, mk(E_M3, 0, 1, 0, 0, 0));
    push(g+11, mk(E_SB, 0, 1, 0, 0, 0));
    push(g+12, mk(E_0,  0, 0, 1, 0, 0));
    done_q.push_back(g+12);
    step(15);

    // MUL23 with simultaneous dones
    dly[3] = 3; dly[4] = 3;
    g = cyc; go = 1'b1;
    for (int c = 4; c <= 7; c++) push(g+c, mk(E_23, 0, 1, 0, 0, 0));
    push(g+8, mk(E_SB, 0, 1, 0, 0, 0));
    done_q.push_back(g+9);
    step(12);
    dly[3] = 0; dly[4] = 0;

    // done_sqrt on the timeout cycle itself still advances
    dly[2] = 7;
    g = cyc; go = 1'b1;
    for (int c = 3; c <= 10; c++) push(g+c, mk(E_SQ, 0, 1, 0, 0, 0));
    push(g+11, mk(E_23, 0, 1, 0, 0, 0));
    push(g+12, mk(E_SB, 0, 1, 0, 0, 0));
    done_q.push_back(g+13);
    step(16);

    // done_sqrt withheld: ERR after 8 cycles, then restart on go
    dly[2] = -1;
    g = cyc; go = 1'b1;
    for (int c = 3; c <= 10; c++) push(g+c, mk(E_SQ, 0, 1, 0, 0, 0));
    push(g+11, mk(E_0, 0, 0, 0, 1, 0));
    push(g+12, mk(E_0, 0, 0, 0, 1, 0));
    step(12);
    dly[2] = 0;
    h = cyc; go = 1'b1;
    push(h+1, mk(E_M1, 0, 1, 0, 0, 0));
    push(h+2, mk(E_NM, 0, 1, 0, 0, 0));
    push(h+7, mk(E_0,  0, 0, 0, 0, 0));
    done_q.push_back(h+6);
    step(10);

    // Abort coincident with the final done_sub: no completion pulse
    g = cyc; go = 1'b1;
    push(g+5, mk(E_SB, 0, 1, 0, 0, 0));
    push(g+6, mk(E_0,  0, 0, 0, 0, 0));
    push(g+7, mk(E_0,  0, 0, 0, 0, 0));
    step(5);
    abort = 1'b1;
    step(6);

    // Reset while NORM is waiting
    dly[1] = -1;
    g = cyc; go = 1'b1;
    push(g+1, mk(E_M1, 0, 1, 0, 0, 0));
    push(g+2, mk(E_NM, 0, 1, 0, 0, 0));
    step(3);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_norm", {18'b0, outv}, 32'd0);
    step(1);
    rst_n = 1'b1; dly[1] = 0;
    step(3);
    chk("idle_after_reset", {18'b0, outv}, 32'd0);

    step(3);
    chk("trace_left", trace_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
